param_updown_counter: RTL and testbench

//  Parametrised up/down counter; next generation of the fixed 4-bit down counter.

---
 rtl/cnt_pkg.sv | 8 +
 rtl/param_updown_counter.sv | 76 +++++++
 tb/tb_param_updown_counter.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/cnt_pkg.sv
// Shared constants for the parametrised up/down counter: terminal-mode encodings.
package cnt_pkg;

    localparam logic [1:0] CNT_WRAP    = 2'b00;
    localparam logic [1:0] CNT_SAT     = 2'b01;
    localparam logic [1:0] CNT_ONESHOT = 2'b10;

endpackage

// File: rtl/param_updown_counter.sv
// Up/down counter with programmable width and modulus, parallel load and
// wrap / saturate / one-shot terminal behaviour.
module param_updown_counter
    import cnt_pkg::*;
#(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned MODULUS   = 2 ** WIDTH,
    parameter int unsigned RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up_dn,
    input  logic [1:0]       mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             zero,
    output logic             done
);

    localparam logic [WIDTH-1:0] MAX   = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] RST_Q = WIDTH'(RESET_VAL);

    logic [WIDTH-1:0] r_q;
    logic             r_tc;
    logic             r_done;

    logic [WIDTH-1:0] w_q_next;
    logic             w_tc_next;
    logic             w_done_next;
    logic             w_at_term;

    assign w_at_term = up_dn ? (r_q == MAX) : (r_q == '0);

    always_comb begin
        w_q_next    = r_q;
        w_tc_next   = 1'b0;
        w_done_next = r_done;
        if (load) begin
            w_q_next    = (load_val > MAX) ? MAX : load_val;
            w_done_next = 1'b0;
        end else if (en && !r_done) begin
            if (!w_at_term) begin
                w_q_next = up_dn ? r_q + 1'b1 : r_q - 1'b1;
            end else begin
                w_tc_next = 1'b1;
                case (mode)
                    CNT_SAT:     w_q_next = r_q;
                    CNT_ONESHOT: w_done_next = 1'b1;
                    // Reserved encoding behaves as wrap.
                    default:     w_q_next = up_dn ? '0 : MAX;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q    <= RST_Q;
            r_tc   <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_q    <= w_q_next;
            r_tc   <= w_tc_next;
            r_done <= w_done_next;
        end
    end

    assign q    = r_q;
    assign tc   = r_tc;
    assign done = r_done;
    assign zero = (r_q == '0);

endmodule

// File: tb/tb_param_updown_counter.sv
// Directed bench for param_updown_counter: a full-range instance (MODULUS 16, reset 0)
// and a decade instance (MODULUS 10, reset 3) share one stimulus set.
module tb_param_updown_counter;

    logic       clk = 1'b0;
    logic       rst, en, up_dn, load;
    logic [1:0] mode;
    logic [3:0] load_val;

    logic [3:0] q16, q10;
    logic       tc16, zero16, done16;
    logic       tc10, zero10, done10;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    param_updown_counter #(.WIDTH(4), .MODULUS(16), .RESET_VAL(0)) dut16 (
        .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .mode(mode), .load(load),
        .load_val(load_val), .q(q16), .tc(tc16), .zero(zero16), .done(done16)
    );

    param_updown_counter #(.WIDTH(4), .MODULUS(10), .RESET_VAL(3)) dut10 (
        .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .mode(mode), .load(load),
        .load_val(load_val), .q(q10), .tc(tc10), .zero(zero10), .done(done10)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [3:0] v);
        load = 1'b1; en = 1'b0; load_val = v;
        tick();
        load = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; up_dn = 1'b0; mode = 2'b00; load = 1'b0; load_val = '0;
        tick();
        tick();
        rst = 1'b0;
        n_vec++;
        if (q16 !== 4'd0 || tc16 !== 1'b0 || done16 !== 1'b0 || zero16 !== 1'b1) begin
            n_err++;
            $display("FAIL reset16: q=%0d tc=%b done=%b zero=%b, want 0 0 0 1",
                     q16, tc16, done16, zero16);
        end
        n_vec++;
        if (q10 !== 4'd3 || tc10 !== 1'b0 || done10 !== 1'b0 || zero10 !== 1'b0) begin
            n_err++;
            $display("FAIL reset10: q=%0d tc=%b done=%b zero=%b, want 3 0 0 0",
                     q10, tc10, done10, zero10);
        end
    endtask

    task automatic test_down_wrap();
        logic [3:0] exp_q [17];
        exp_q = '{4'd15, 4'd14, 4'd13, 4'd12, 4'd11, 4'd10, 4'd9, 4'd8, 4'd7,
                  4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0, 4'd15};
        mode = 2'b00; up_dn = 1'b0; en = 1'b1;
        for (int i = 0; i < 17; i++) begin
            tick();
            n_vec++;
            // tc follows each 0 -> 15 wrap (first and last step).
            if (q16 !== exp_q[i] || tc16 !== (i == 0 || i == 16) ||
                zero16 !== (exp_q[i] == 4'd0)) begin
                n_err++;
                $display("FAIL down_wrap[%0d]: q=%0d tc=%b zero=%b, want q=%0d", i, q16, tc16,
                         zero16, exp_q[i]);
            end
        end
        en = 1'b0;
    endtask

    task automatic test_mod10_up_wrap();
        logic [3:0] exp_q [10];
        exp_q = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd0};
        mode = 2'b00;
        do_load(4'd0);
        up_dn = 1'b1; en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_vec++;
            if (q10 !== exp_q[i] || tc10 !== (i == 9)) begin
                n_err++;
                $display("FAIL mod10_wrap[%0d]: q=%0d tc=%b, want q=%0d tc=%b", i, q10, tc10,
                         exp_q[i], (i == 9));
            end
        end
        en = 1'b0;
    endtask

    task automatic test_saturate();
        mode = 2'b01; up_dn = 1'b1;
        do_load(4'd14);
        en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_vec++;
            if (q16 !== 4'd15 || tc16 !== (i != 0) || done16 !== 1'b0) begin
                n_err++;
                $display("FAIL saturate[%0d]: q=%0d tc=%b done=%b, want 15 %b 0", i, q16, tc16,
                         done16, (i != 0));
            end
        end
        en = 1'b0;
        tick();
        n_vec++;
        if (q16 !== 4'd15 || tc16 !== 1'b0) begin
            n_err++;
            $display("FAIL en_low_hold: q=%0d tc=%b, want 15 0", q16, tc16);
        end
    endtask

    task automatic test_oneshot();
        mode = 2'b10; up_dn = 1'b0;
        do_load(4'd3);
        en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_vec++;
            if (q16 !== 4'(2 - i) || tc16 !== 1'b0 || done16 !== 1'b0) begin
                n_err++;
                $display("FAIL oneshot_cnt[%0d]: q=%0d tc=%b done=%b, want %0d 0 0", i, q16,
                         tc16, done16, 2 - i);
            end
        end
        tick();
        n_vec++;
        if (q16 !== 4'd0 || tc16 !== 1'b1 || done16 !== 1'b1) begin
            n_err++;
            $display("FAIL oneshot_term: q=%0d tc=%b done=%b, want 0 1 1", q16, tc16, done16);
        end
        // Halted: en ignored even with a direction change.
        up_dn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_vec++;
            if (q16 !== 4'd0 || tc16 !== 1'b0 || done16 !== 1'b1) begin
                n_err++;
                $display("FAIL oneshot_halt[%0d]: q=%0d tc=%b done=%b, want 0 0 1", i, q16,
                         tc16, done16);
            end
        end
        do_load(4'd5);
        n_vec++;
        if (q16 !== 4'd5 || tc16 !== 1'b0 || done16 !== 1'b0) begin
            n_err++;
            $display("FAIL oneshot_reload: q=%0d tc=%b done=%b, want 5 0 0", q16, tc16, done16);
        end
    endtask

    task automatic test_clamp_and_reset();
        mode = 2'b00; up_dn = 1'b1;
        load = 1'b1; en = 1'b1; load_val = 4'd12;
        tick();
        load = 1'b0; en = 1'b0;
        n_vec++;
        if (q10 !== 4'd9 || q16 !== 4'd12) begin
            n_err++;
            $display("FAIL clamp: q10=%0d q16=%0d, want 9 12", q10, q16);
        end
        do_load(4'd5);
        en = 1'b1;
        tick();
        n_vec++;
        if (q10 !== 4'd6 || q16 !== 4'd6) begin
            n_err++;
            $display("FAIL pre_reset: q10=%0d q16=%0d, want 6 6", q10, q16);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0; en = 1'b0;
        n_vec++;
        if (q10 !== 4'd3 || q16 !== 4'd0 || done10 !== 1'b0 || done16 !== 1'b0 ||
            tc10 !== 1'b0 || tc16 !== 1'b0) begin
            n_err++;
            $display("FAIL mid_reset: q10=%0d q16=%0d done=%b%b tc=%b%b, want 3 0 00 00",
                     q10, q16, done10, done16, tc10, tc16);
        end
    endtask

    task automatic test_dir_toggle();
        logic [3:0] exp_q [6];
        logic       dir [6];
        exp_q = '{4'd6, 4'd7, 4'd6, 4'd5, 4'd6, 4'd7};
        dir   = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        mode = 2'b00;
        do_load(4'd5);
        en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            up_dn = dir[i];
            tick();
            n_vec++;
            if (q16 !== exp_q[i] || q10 !== exp_q[i] || zero16 !== 1'b0) begin
                n_err++;
                $display("FAIL dir_toggle[%0d]: q16=%0d q10=%0d zero=%b, want %0d", i, q16, q10,
                         zero16, exp_q[i]);
            end
        end
        en = 1'b0;
    endtask

    task automatic test_reserved_mode();
        mode = 2'b11; up_dn = 1'b1;
        do_load(4'd9);
        en = 1'b1;
        tick();
        en = 1'b0;
        n_vec++;
        if (q10 !== 4'd0 || tc10 !== 1'b1 || zero10 !== 1'b1 || done10 !== 1'b0) begin
            n_err++;
            $display("FAIL reserved_wrap: q=%0d tc=%b zero=%b done=%b, want 0 1 1 0", q10, tc10,
                     zero10, done10);
        end
    endtask

    initial begin
        test_reset();
        test_down_wrap();
        test_mod10_up_wrap();
        test_saturate();
        test_oneshot();
        test_clamp_and_reset();
        test_dir_toggle();
        test_reserved_mode();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
